// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: strobed bits are counted into a WIDTH-bit word, presented with valid/ack.
// Latency: p_valid rises one clock after the bit_en that carries the last bit of a frame.
// Backpressure: none toward the link; an unacked word is overwritten by the next one and ovr pulses.
module shift_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       bit_en,
  input  logic                       sdata,
  input  logic                       msb_first,
  input  logic                       p_ack,
  output logic [WIDTH-1:0]           p_out,
  output logic                       p_valid,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       ovr,
  output logic                       frm_err
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] pout_d;
  logic [CW-1:0]    cnt_d;
  logic             dir_q, dir_d;
  logic             pvalid_d, ovr_d, frm_d;
  logic             last_bit;

  // Shift register contents after accepting sdata in the direction latched at frame start.
  always_comb begin
    shifted = dir_q ? {sr_q[WIDTH-2:0], sdata} : {sdata, sr_q[WIDTH-1:1]};
  end

  // The bit that fills the word; only meaningful while receiving.
  always_comb begin
    last_bit = bit_en && (bit_cnt == CW'(WIDTH-1));
  end

  // Next-state and datapath: completion is evaluated first so a restart on the same edge
  // still delivers the finished word, then the restart overrides state and counter.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = bit_cnt;
    dir_d    = dir_q;
    pout_d   = p_out;
    pvalid_d = p_valid;
    ovr_d    = 1'b0;
    frm_d    = 1'b0;

    if (p_valid && p_ack) begin
      pvalid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RECV;
          cnt_d   = '0;
          sr_d    = '0;
          dir_d   = msb_first;
        end
      end
      RECV: begin
        if (last_bit) begin
          pout_d   = shifted;
          pvalid_d = 1'b1;
          ovr_d    = p_valid && !p_ack;
          state_d  = IDLE;
          cnt_d    = '0;
          sr_d     = '0;
        end
        if (start) begin
          frm_d   = 1'b1;
          state_d = RECV;
          cnt_d   = '0;
          sr_d    = '0;
          dir_d   = msb_first;
        end else if (bit_en && !last_bit) begin
          sr_d  = shifted;
          cnt_d = bit_cnt + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_cnt <= '0;
      dir_q   <= 1'b0;
      p_out   <= '0;
      p_valid <= 1'b0;
      ovr     <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_cnt <= cnt_d;
      dir_q   <= dir_d;
      p_out   <= pout_d;
      p_valid <= pvalid_d;
      ovr     <= ovr_d;
      frm_err <= frm_d;
    end
  end

  assign busy = (state_q == RECV);

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: directed scenarios with literal expectations plus randomized traffic.
// A queue-based reference model predicts every output and is compared on each falling edge.
// Inputs change 1 time unit after the rising edge; literal checks are taken at the same point.
module tb_shift_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         bit_en = 1'b0;
  logic         sdata = 1'b0;
  logic         msb_first = 1'b1;
  logic         p_ack = 1'b0;
  logic [W-1:0] p_out;
  logic         p_valid;
  logic         busy;
  logic [3:0]   bit_cnt;
  logic         ovr;
  logic         frm_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic seen_frm;

  shift_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .bit_en(bit_en), .sdata(sdata),
    .msb_first(msb_first), .p_ack(p_ack), .p_out(p_out), .p_valid(p_valid),
    .busy(busy), .bit_cnt(bit_cnt), .ovr(ovr), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit           m_q[$];
  bit           m_busy = 1'b0;
  bit           m_dir = 1'b0;
  logic [W-1:0] m_pout = '0;
  bit           m_pvalid = 1'b0;
  bit           m_ovr = 1'b0;
  bit           m_frm = 1'b0;

  // Word built from bits in arrival order: first bit lands at the top (msb-first) or bottom.
  function automatic logic [W-1:0] assemble(input bit dir);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (dir) w[W-1-i] = m_q[i];
      else     w[i]     = m_q[i];
    end
    return w;
  endfunction

  always @(posedge clk) begin
    bit completed;
    completed = 1'b0;
    if (reset) begin
      m_q.delete();
      m_busy = 0; m_dir = 0; m_pout = '0; m_pvalid = 0; m_ovr = 0; m_frm = 0;
    end else begin
      bit old_valid;
      old_valid = m_pvalid;
      m_ovr = 0;
      m_frm = 0;
      if (m_pvalid && p_ack) m_pvalid = 0;
      if (m_busy) begin
        if (bit_en && m_q.size() == W-1) begin
          m_q.push_back(sdata);
          m_pout = assemble(m_dir);
          m_ovr = old_valid && !p_ack;
          m_pvalid = 1;
          m_busy = 0;
          m_q.delete();
          completed = 1'b1;
        end
        if (start) begin
          m_frm = 1;
          m_busy = 1;
          m_dir = msb_first;
          m_q.delete();
        end else if (bit_en && !completed) begin
          m_q.push_back(sdata);
        end
      end else if (start) begin
        m_busy = 1;
        m_dir = msb_first;
        m_q.delete();
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_p_out",   32'(p_out),   32'(m_pout));
      chk("m_p_valid", 32'(p_valid), 32'(m_pvalid));
      chk("m_busy",    32'(busy),    32'(m_busy));
      chk("m_bit_cnt", 32'(bit_cnt), m_busy ? 32'(m_q.size()) : 32'd0);
      chk("m_ovr",     32'(ovr),     32'(m_ovr));
      chk("m_frm_err", 32'(frm_err), 32'(m_frm));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic dir, input logic [7:0] w, input int gap, input bit chk_cnt);
    msb_first = dir;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen_frm = frm_err;
    if (chk_cnt) begin
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("cnt_after_start", 32'(bit_cnt), 32'd0);
    end
    for (int i = 0; i < W; i++) begin
      sdata = dir ? w[7-i] : w[i];
      bit_en = 1'b1;
      tick();
      bit_en = 1'b0;
      if (chk_cnt) chk("cnt_step", 32'(bit_cnt), (i == W-1) ? 32'd0 : 32'(i+1));
      if (i < W-1) begin
        repeat (gap) begin
          tick();
          if (chk_cnt) chk("cnt_hold", 32'(bit_cnt), 32'(i+1));
        end
      end
    end
  endtask

  task automatic ack_once();
    p_ack = 1'b1;
    tick();
    p_ack = 1'b0;
    chk("ack_clears", 32'(p_valid), 32'd0);
  endtask

  initial begin
    // T1: reset, then msb-first 0,1,0,0,1,0,1,0
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_p_out", 32'(p_out), 32'd0);
    chk("rst_p_valid", 32'(p_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    send_frame(1'b1, 8'h4A, 0, 1'b0);
    chk("t1_p_out", 32'(p_out), 32'h4A);
    chk("t1_p_valid", 32'(p_valid), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    ack_once();

    // T2: same bit order, lsb-first
    send_frame(1'b0, 8'h52, 0, 1'b0);
    chk("t2_p_out", 32'(p_out), 32'h52);
    ack_once();

    // T3: gaps between bits
    send_frame(1'b1, 8'hA5, 3, 1'b1);
    chk("t3_p_out", 32'(p_out), 32'hA5);
    chk("t3_p_valid", 32'(p_valid), 32'd1);
    ack_once();

    // T4: overrun with no ack
    send_frame(1'b1, 8'h4A, 0, 1'b0);
    chk("t4_no_ovr_first", 32'(ovr), 32'd0);
    send_frame(1'b1, 8'hFF, 0, 1'b0);
    chk("t4_ovr", 32'(ovr), 32'd1);
    chk("t4_p_out", 32'(p_out), 32'hFF);
    chk("t4_p_valid", 32'(p_valid), 32'd1);
    tick();
    chk("t4_ovr_pulse", 32'(ovr), 32'd0);
    ack_once();

    // T5: aborted frame then 8'h3C
    msb_first = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sdata = i[0];
      bit_en = 1'b1;
      tick();
    end
    bit_en = 1'b0;
    send_frame(1'b1, 8'h3C, 0, 1'b0);
    chk("t5_frm_err", 32'(seen_frm), 32'd1);
    chk("t5_p_out", 32'(p_out), 32'h3C);
    ack_once();

    // T6: reset mid-frame, then 8'h81
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sdata = 1'b1;
      bit_en = 1'b1;
      tick();
    end
    bit_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_p_out", 32'(p_out), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_bit_cnt", 32'(bit_cnt), 32'd0);
    send_frame(1'b0, 8'h81, 1, 1'b0);
    chk("t6_p_out_81", 32'(p_out), 32'h81);

    // Randomized traffic checked only by the model
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(0, 599) == 0);
      start     = ($urandom_range(0, 14) == 0);
      bit_en    = ($urandom_range(0, 2) != 0);
      sdata     = $urandom_range(0, 1) == 1;
      msb_first = $urandom_range(0, 1) == 1;
      p_ack     = ($urandom_range(0, 3) == 0);
      tick();
    end
    reset = 1'b0; start = 1'b0; bit_en = 1'b0; p_ack = 1'b0;
    tick();
    tick();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
